// File: rtl/audio_out_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : audio_out_reader_if
// Brief   : Read-only data RAM port used by the audio output reader.
// Revision: 1.0 - initial release
// ============================================================================
interface audio_out_reader_if;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/audio_out_reader.sv
`default_nettype none
// ============================================================================
// Module  : audio_out_reader
// Brief   : Fetches song-buffer words at the sample rate; emits 16-bit samples
//           with a valid strobe and a PWM audio output.
// Revision: 1.0 - initial release
// ============================================================================
module audio_out_reader #(
    parameter int          DIV       = 2267,
    parameter int          BUF_WORDS = 1024,
    parameter logic [31:0] BASE0     = 32'h400,
    parameter logic [31:0] BASE1     = 32'h800,
    parameter int          PWM_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic              loop,
    input  wire logic              SongSelector,
    audio_out_reader_if.master     mem,
    output logic [15:0]            sample_out,
    output logic                   sample_valid,
    output logic                   pwm_out,
    output logic                   busy,
    output logic                   done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [31:0]        r_base;
    logic [IDX_W-1:0]   r_idx;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [15:0]        r_next_smp;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [15:0]        r_sample_out;
    logic               r_sample_valid;
    logic               r_pwm_out;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_en;
    logic [31:0]        r_addr;

    logic               w_tick;
    logic [IDX_W-1:0]   w_idx_next;
    logic [PWM_W-1:0]   w_duty;
    logic               w_unused_rdata_hi;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_idx_next = r_idx + 1'b1;
    // Offset-binary duty: flipping the sign bit maps silence to 50 %.
    assign w_duty     = {~r_sample_out[15], r_sample_out[14:16-PWM_W]};
    assign w_unused_rdata_hi = ^mem.mem_rdata[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_base         <= '0;
            r_idx          <= '0;
            r_div_cnt      <= '0;
            r_next_smp     <= '0;
            r_pwm_cnt      <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_pwm_out      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rd_en        <= 1'b0;
            r_addr         <= '0;
        end else begin
            r_pwm_cnt      <= r_pwm_cnt + 1'b1;
            r_pwm_out      <= (r_pwm_cnt < w_duty);
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
            r_rd_en        <= 1'b0;
            r_addr         <= '0;

            if (r_state != S_IDLE) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= SongSelector ? BASE1 : BASE0;
                        r_idx     <= '0;
                        r_div_cnt <= '0;
                        r_state   <= S_FETCH;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_addr    <= SongSelector ? BASE1 : BASE0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_next_smp <= mem.mem_rdata[15:0];
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_sample_out   <= r_next_smp;
                        r_sample_valid <= 1'b1;
                        if (r_idx == IDX_LAST) begin
                            if (loop) begin
                                r_idx   <= '0;
                                r_state <= S_FETCH;
                                r_rd_en <= 1'b1;
                                r_addr  <= r_base;
                            end else begin
                                r_done    <= 1'b1;
                                r_state   <= S_IDLE;
                                r_busy    <= 1'b0;
                                r_div_cnt <= '0;
                            end
                        end else begin
                            r_idx   <= w_idx_next;
                            r_state <= S_FETCH;
                            r_rd_en <= 1'b1;
                            r_addr  <= r_base + 32'(w_idx_next);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Abort overrides everything decided above, including a tick.
            if (stop && (r_state != S_IDLE)) begin
                r_state        <= S_IDLE;
                r_busy         <= 1'b0;
                r_div_cnt      <= '0;
                r_sample_out   <= '0;
                r_sample_valid <= 1'b0;
                r_done         <= 1'b0;
                r_rd_en        <= 1'b0;
                r_addr         <= '0;
            end
        end
    end

    assign mem.mem_rd_en = r_rd_en;
    assign mem.mem_addr  = r_addr;
    assign sample_out    = r_sample_out;
    assign sample_valid  = r_sample_valid;
    assign pwm_out       = r_pwm_out;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_audio_out_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_audio_out_reader
// Brief   : Randomized scoreboard bench for audio_out_reader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_audio_out_reader;

    localparam int DIV = 8;
    localparam int BUF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        SongSelector = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        pwm_out;
    logic        busy;
    logic        done;

    audio_out_reader_if bus ();

    audio_out_reader #(
        .DIV       (DIV),
        .BUF_WORDS (BUF),
        .BASE0     (32'h400),
        .BASE1     (32'h800),
        .PWM_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .SongSelector (SongSelector),
        .mem          (bus.master),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .pwm_out      (pwm_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] ram0 [BUF];
    logic [31:0] ram1 [BUF];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (a >= 32'h400 && a < 32'h400 + BUF) return ram0[int'(a - 32'h400)];
        if (a >= 32'h800 && a < 32'h800 + BUF) return ram1[int'(a - 32'h800)];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram_rd(bus.mem_addr);
    end

    typedef struct {
        logic [15:0] smp;
        logic        dn;
        int          cyc;
    } smp_exp_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } rd_exp_t;

    smp_exp_t sq[$];
    rd_exp_t  rq[$];
    smp_exp_t se;
    rd_exp_t  re;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of a queue.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (sq.size() == 0) begin
                check("spurious_valid", {31'd0, sample_valid}, 32'd0);
            end else begin
                se = sq.pop_front();
                check("sample", {16'd0, sample_out}, {16'd0, se.smp});
                check("done_flag", {31'd0, done}, {31'd0, se.dn});
                check("valid_cycle", 32'(cyc), 32'(se.cyc));
            end
        end else if (done) begin
            check("done_alone", {31'd0, done}, 32'd0);
        end
        if (bus.mem_rd_en) begin
            if (rq.size() == 0) begin
                check("spurious_read", {31'd0, bus.mem_rd_en}, 32'd0);
            end else begin
                re = rq.pop_front();
                check("read_addr", bus.mem_addr, re.addr);
                check("read_cycle", 32'(cyc), 32'(re.cyc));
            end
        end
    end

    task automatic fill_ram();
        for (int i = 0; i < BUF; i++) begin
            ram0[i] = $urandom;
            ram1[i] = $urandom;
        end
    endtask

    task automatic check_idle_outputs(input bit cleared, input logic [15:0] held);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("rd_en_idle", {31'd0, bus.mem_rd_en}, 32'd0);
        check("addr_idle", bus.mem_addr, 32'd0);
        check("sample_after", {16'd0, sample_out}, cleared ? 32'd0 : {16'd0, held});
    endtask

    // One playback; stop_off > 0 aborts (stop or rst) at edge t0+stop_off.
    task automatic play(input bit song, input bit lp, input int stop_off,
                        input bit use_rst, input bit extra_start);
        int          t0;
        int          nsmp;
        int          nrd;
        logic [31:0] base;
        logic [31:0] w;
        bit          finished_first;
        @(negedge clk);
        SongSelector = song;
        loop         = lp;
        start        = 1'b1;
        t0           = cyc + 1;
        base         = song ? 32'h800 : 32'h400;
        if (stop_off == 0) begin
            nsmp = BUF;
            nrd  = BUF;
        end else begin
            nsmp = 0;
            while ((nsmp + 1) * DIV < stop_off && (lp || nsmp < BUF)) nsmp++;
            nrd = 0;
            while (nrd * DIV < stop_off && (lp || nrd < BUF)) nrd++;
        end
        for (int k = 0; k < nsmp; k++) begin
            w = song ? ram1[k % BUF] : ram0[k % BUF];
            sq.push_back('{w[15:0], !lp && (k == BUF - 1), t0 + (k + 1) * DIV});
        end
        for (int k = 0; k < nrd; k++) begin
            rq.push_back('{base + 32'(k % BUF), t0 + k * DIV});
        end
        @(negedge clk);
        start        = 1'b0;
        SongSelector = 1'($urandom);
        if (extra_start) begin
            while (cyc < t0 + 4) @(negedge clk);
            start        = 1'b1;
            SongSelector = ~song;
            @(negedge clk);
            start = 1'b0;
        end
        w = song ? ram1[BUF - 1] : ram0[BUF - 1];
        if (stop_off > 0) begin
            while (cyc < t0 + stop_off - 1) @(negedge clk);
            if (use_rst) rst = 1'b1;
            else         stop = 1'b1;
            @(negedge clk);
            rst  = 1'b0;
            stop = 1'b0;
            finished_first = !lp && (BUF * DIV < stop_off);
            check_idle_outputs(!finished_first, w[15:0]);
            check("valid_after_abort", {31'd0, sample_valid}, 32'd0);
            check("done_after_abort", {31'd0, done}, 32'd0);
            if (use_rst) check("pwm_after_rst", {31'd0, pwm_out}, 32'd0);
        end else begin
            while (cyc < t0 + BUF * DIV + 1) @(negedge clk);
            check_idle_outputs(1'b0, w[15:0]);
        end
        repeat (2 * DIV) @(negedge clk);
        check("sample_queue_empty", 32'(sq.size()), 32'd0);
        check("read_queue_empty", 32'(rq.size()), 32'd0);
        sq.delete();
        rq.delete();
    endtask

    task automatic pwm_check(input logic [15:0] s);
        int cnt;
        int exp_cnt;
        cnt = 0;
        repeat (4) @(negedge clk);
        repeat (256) begin
            @(negedge clk);
            cnt += int'(pwm_out);
        end
        exp_cnt = (int'($signed(s)) + 32768) / 256;
        check("pwm_high_count", 32'(cnt), 32'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] pv [4];
        pv[0] = 16'h7FFF;
        pv[1] = 16'h8000;
        pv[2] = 16'h0000;
        pv[3] = 16'($urandom);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sample", {16'd0, sample_out}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_pwm", {31'd0, pwm_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        rst = 1'b0;

        fill_ram();
        for (int i = 0; i < BUF; i++) ram0[i] = {16'($urandom), 16'(i + 1)};
        play(1'b0, 1'b0, 0, 1'b0, 1'b0);

        fill_ram();
        play(1'b1, 1'b1, 6 * DIV + 3, 1'b0, 1'b0);

        play(1'b0, 1'b0, 14, 1'b0, 1'b0);
        play(1'b0, 1'b0, 0, 1'b0, 1'b0);

        fill_ram();
        play(1'b0, 1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            fill_ram();
            ram0[BUF - 1][15:0] = pv[i];
            play(1'b0, 1'b0, 0, 1'b0, 1'b0);
            pwm_check(pv[i]);
        end

        fill_ram();
        play(1'b1, 1'b0, 3, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int so;
            fill_ram();
            so = (r % 3 == 0) ? 0 : $urandom_range(6, 7 * DIV);
            play(1'($urandom), (so == 0) ? 1'b0 : 1'($urandom), so,
                 (so != 0) && (r % 4 == 1), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
